overlay_mixer: RTL and testbench
================================

# overlay_mixer

Downstream compositing stage for the emblem overlay. Each pixel, it blends the overlay colour onto the background colour using a frame-stepped fade alpha, treating the overlay transparent key as see-through. It blanks outside the active display region. It re-times hsync/vsync so they stay aligned with the registered colour driven to the TinyVGA PMOD.

## Interface

Parameters:
- `FADE_FRAMES`, default 8 — frames per alpha step; legal range 1..255.
- `TRANSPARENT`, default 6'b100001 — overlay colour key treated as "no overlay".

Ports:
- `clk` input 1 — pixel clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `hsync_in` input 1 — horizontal sync from the timing generator, active-low.
- `vsync_in` input 1 — vertical sync from the timing generator, active-low.
- `display_on` input 1 — pixel is inside the visible area.
- `bg_rgb` input 6 — background colour.
- `ovl_rgb` input 6 — overlay colour from the emblem generator.
- `show` input 1 — level request for the overlay to be visible.
- `rgb_out` output 6 — composited colour.
- `hsync_out` output 1 — `hsync_in` delayed to match `rgb_out`.
- `vsync_out` output 1 — `vsync_in` delayed to match `rgb_out`.
- `alpha` output 3 — current overlay weight, 0..4.
- `fade_state` output 2 — 0 HIDDEN, 1 FADE_IN, 2 SHOWN, 3 FADE_OUT.

Colour format for all 6-bit colours: {R1,G1,B1,R0,G0,B0}. Channel c = {c1,c0}.

## Operation

- **Frame tick:** asserted one cycle on a falling edge of the stage-1 registered `vsync_in`. Alpha and state change only on a tick, so every visible frame uses a single alpha.
- **Step counter:** `step_cnt` is 8 bits. It counts ticks 0..FADE_FRAMES-1 while in FADE_IN or FADE_OUT. A step fires on a tick with step_cnt == FADE_FRAMES-1, after which step_cnt returns to 0. step_cnt also clears on every state change.
- **State machine** (`show` is sampled only on ticks):
  - HIDDEN (alpha=0): tick with show=1 → FADE_IN, alpha=1.
  - FADE_IN: tick with show=0 → FADE_OUT, alpha unchanged. Otherwise, on a step, alpha+1; reaching 4 → SHOWN.
  - SHOWN (alpha=4): tick with show=0 → FADE_OUT, alpha=3.
  - FADE_OUT: tick with show=1 → FADE_IN, alpha unchanged. Otherwise, on a step, alpha-1; reaching 0 → HIDDEN.
- **Blend**, per 2-bit channel: out = (ovl·alpha + bg·(4−alpha)) >> 2.
  - The intermediate is 4 bits wide with no overflow (max 12).
  - alpha=0 yields bg exactly; alpha=4 yields ovl exactly.
- **Transparency:** if ovl_rgb == TRANSPARENT, out = bg_rgb regardless of alpha.
- **Blanking:** if display_on=0, rgb_out = 6'b000000.

## Timing

- **Pipeline (latency 2 cycles for all of rgb/hsync/vsync):**
  - Stage 1 registers bg_rgb, ovl_rgb, display_on, hsync_in and vsync_in.
  - Stage 2 computes the blend and registers rgb_out, hsync_out and vsync_out.
- **Alpha update:** alpha/fade_state update in the cycle after the tick is detected, i.e. 2 cycles after the vsync_in falling edge. This falls inside vertical blanking, so there is no mid-frame change.
- **Reset values:**
  - rgb_out=0; hsync_out=1; vsync_out=1.
  - alpha=0; fade_state=HIDDEN; step_cnt=0.
  - Stage-1 sync registers = 1, so no false tick is generated after reset release.
- **Reset mid-fade:** returns immediately to HIDDEN/alpha 0. The overlay reappears only via a new FADE_IN.
- **Tick with simultaneous step and show reversal:** the reversal wins; alpha is unchanged on that tick.

## Configuration

- `OVERLAY_FADE_EN` defined: fade behaviour as above.
- `OVERLAY_FADE_EN` undefined:
  - FADE_IN and FADE_OUT are unreachable. A tick with show=1 in HIDDEN moves to SHOWN with alpha=4; a tick with show=0 in SHOWN moves to HIDDEN with alpha=0.
  - step_cnt is removed and FADE_FRAMES is ignored.
  - Blend reduces to a mux between ovl and bg.

## Test plan

- **Reset/passthrough:** rst_n=0 then release; show=0, bg=6'b010101, ovl=6'b111111, display_on=1 → rgb_out=6'b010101 two cycles later; hsync_out/vsync_out equal the inputs delayed by 2.
- **Fade-in timing:** FADE_FRAMES=2, show=1 before tick 0 → alpha 1 after tick 0; 2 after tick 2; 3 after tick 4; 4 and SHOWN after tick 6.
- **Blend value:** alpha=2, ovl red=11, bg red=01, other channels 0 → red=(6+2)>>2=10, i.e. rgb_out=6'b100000.
- **Transparency and blanking:** ovl_rgb=6'b100001 at alpha=4 → rgb_out=bg_rgb. display_on=0 with any inputs → rgb_out=0 two cycles later.
- **Reversal:** show drops while FADE_IN alpha=2 → after the next tick FADE_OUT, alpha 2; then decrements every FADE_FRAMES ticks to 0/HIDDEN.
- **Macro off:** build without OVERLAY_FADE_EN; show=1 → alpha jumps 0→4 on the first tick; show=0 → 4→0 on the next tick.

Source files
------------

// File: rtl/overlay_mixer.sv
// overlay_mixer
//
// Downstream compositing stage for the emblem overlay. Blends the overlay
// colour onto the background with a frame-stepped fade weight, treats the
// overlay colour key as see-through, blanks outside the visible area, and
// re-times hsync/vsync so they stay aligned with the registered colour.
//
// Build option:
//   OVERLAY_FADE_EN defined   - alpha fades 0..4 in steps of FADE_FRAMES frames.
//   OVERLAY_FADE_EN undefined - overlay switches fully on/off on a frame tick,
//                               FADE_FRAMES is ignored.
//
// Parameters:
//   FADE_FRAMES  frames per alpha step (1..255)
//   TRANSPARENT  overlay colour key meaning "no overlay"
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   hsync_in    horizontal sync, active-low
//   vsync_in    vertical sync, active-low
//   display_on  pixel is inside the visible area
//   bg_rgb      background colour {R1,G1,B1,R0,G0,B0}
//   ovl_rgb     overlay colour {R1,G1,B1,R0,G0,B0}
//   show        level request for the overlay to be visible
//   rgb_out     composited colour, 2 cycles after the inputs
//   hsync_out   hsync_in delayed by 2 cycles
//   vsync_out   vsync_in delayed by 2 cycles
//   alpha       current overlay weight 0..4
//   fade_state  0 HIDDEN, 1 FADE_IN, 2 SHOWN, 3 FADE_OUT
//
// State table:
//   state    | meaning
//   HIDDEN   | overlay invisible, alpha = 0
//   FADE_IN  | alpha rising one step every FADE_FRAMES ticks
//   SHOWN    | overlay fully visible, alpha = 4
//   FADE_OUT | alpha falling one step every FADE_FRAMES ticks

module overlay_mixer #(
    parameter int          FADE_FRAMES = 8,
    parameter logic [5:0]  TRANSPARENT = 6'b100001
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       display_on,
    input  logic [5:0] bg_rgb,
    input  logic [5:0] ovl_rgb,
    input  logic       show,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [2:0] alpha,
    output logic [1:0] fade_state
);

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_t;

    // ---------------------------------------------------------------
    // Stage 1: input registers
    // ---------------------------------------------------------------
    logic [5:0] bg_s1;
    logic [5:0] ovl_s1;
    logic       de_s1;
    logic       hs_s1;
    logic       vs_s1;

    // Sync registers reset high so releasing reset never looks like a
    // vsync falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_s1  <= 6'b000000;
            ovl_s1 <= 6'b000000;
            de_s1  <= 1'b0;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
        end else begin
            bg_s1  <= bg_rgb;
            ovl_s1 <= ovl_rgb;
            de_s1  <= display_on;
            hs_s1  <= hsync_in;
            vs_s1  <= vsync_in;
        end
    end

    // vsync_out is vs_s1 delayed by one cycle, so it doubles as the
    // previous-value register for edge detection.
    logic tick;
    assign tick = vsync_out & ~vs_s1;

    // ---------------------------------------------------------------
    // Fade state machine
    // ---------------------------------------------------------------
    fade_t      state_q;
    fade_t      state_nx;
    logic [2:0] alpha_q;
    logic [2:0] alpha_nx;

`ifdef OVERLAY_FADE_EN
    localparam logic [7:0] LAST_CNT = 8'(FADE_FRAMES - 1);

    logic [7:0] step_cnt;
    logic [7:0] step_cnt_nx;
    logic       step;

    assign step = tick && (step_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HIDDEN;
            alpha_q  <= 3'd0;
            step_cnt <= 8'd0;
        end else begin
            state_q  <= state_nx;
            alpha_q  <= alpha_nx;
            step_cnt <= step_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        alpha_nx    = alpha_q;
        step_cnt_nx = step_cnt;
        if (tick) begin
            case (state_q)
                HIDDEN: begin
                    if (show) begin
                        state_nx    = FADE_IN;
                        alpha_nx    = 3'd1;
                        step_cnt_nx = 8'd0;
                    end
                end
                FADE_IN: begin
                    // A show reversal overrides a coincident step.
                    if (!show) begin
                        state_nx    = FADE_OUT;
                        step_cnt_nx = 8'd0;
                    end else if (step) begin
                        alpha_nx    = alpha_q + 3'd1;
                        step_cnt_nx = 8'd0;
                        if (alpha_q == 3'd3) begin
                            state_nx = SHOWN;
                        end
                    end else begin
                        step_cnt_nx = step_cnt + 8'd1;
                    end
                end
                SHOWN: begin
                    if (!show) begin
                        state_nx    = FADE_OUT;
                        alpha_nx    = 3'd3;
                        step_cnt_nx = 8'd0;
                    end
                end
                FADE_OUT: begin
                    if (show) begin
                        state_nx    = FADE_IN;
                        step_cnt_nx = 8'd0;
                    end else if (step) begin
                        alpha_nx    = alpha_q - 3'd1;
                        step_cnt_nx = 8'd0;
                        if (alpha_q == 3'd1) begin
                            state_nx = HIDDEN;
                        end
                    end else begin
                        step_cnt_nx = step_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nx    = HIDDEN;
                    alpha_nx    = 3'd0;
                    step_cnt_nx = 8'd0;
                end
            endcase
        end
    end

    // Per-channel weighted blend; worst case 3*4 = 12 fits in 4 bits.
    function automatic logic [1:0] mix(input logic [1:0] o,
                                       input logic [1:0] b,
                                       input logic [2:0] a);
        logic [3:0] sum;
        sum = (4'(o) * 4'(a)) + (4'(b) * 4'(3'd4 - a));
        return sum[3:2];
    endfunction

    logic [1:0] ch_r;
    logic [1:0] ch_g;
    logic [1:0] ch_b;
    logic [5:0] blended;

    always_comb begin
        ch_r    = mix({ovl_s1[5], ovl_s1[2]}, {bg_s1[5], bg_s1[2]}, alpha_q);
        ch_g    = mix({ovl_s1[4], ovl_s1[1]}, {bg_s1[4], bg_s1[1]}, alpha_q);
        ch_b    = mix({ovl_s1[3], ovl_s1[0]}, {bg_s1[3], bg_s1[0]}, alpha_q);
        blended = {ch_r[1], ch_g[1], ch_b[1], ch_r[0], ch_g[0], ch_b[0]};
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HIDDEN;
            alpha_q <= 3'd0;
        end else begin
            state_q <= state_nx;
            alpha_q <= alpha_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        alpha_nx = alpha_q;
        if (tick) begin
            case (state_q)
                HIDDEN: begin
                    if (show) begin
                        state_nx = SHOWN;
                        alpha_nx = 3'd4;
                    end
                end
                SHOWN: begin
                    if (!show) begin
                        state_nx = HIDDEN;
                        alpha_nx = 3'd0;
                    end
                end
                default: begin
                    state_nx = HIDDEN;
                    alpha_nx = 3'd0;
                end
            endcase
        end
    end

    // Only full on or full off exists, so the blend is a plain select.
    logic [5:0] blended;
    assign blended = (state_q == SHOWN) ? ovl_s1 : bg_s1;
`endif

    // ---------------------------------------------------------------
    // Stage 2: composite and re-timed syncs
    // ---------------------------------------------------------------
    logic [5:0] pixel;

    always_comb begin
        pixel = blended;
        if (ovl_s1 == TRANSPARENT) begin
            pixel = bg_s1;
        end
        if (!de_s1) begin
            pixel = 6'b000000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= 6'b000000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb_out   <= pixel;
            hsync_out <= hs_s1;
            vsync_out <= vs_s1;
        end
    end

    assign alpha      = alpha_q;
    assign fade_state = state_q;

endmodule

// File: tb/tb_overlay_mixer.sv
// Bench for overlay_mixer: frames of randomized pixels with directed
// fade sequences, checked against a frame-level model of the fade weight
// and a per-channel arithmetic model of the blend.
module tb_overlay_mixer;

    localparam int         FF = 2;
    localparam logic [5:0] TK = 6'b100001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       display_on = 1'b0;
    logic [5:0] bg_rgb = 6'b0;
    logic [5:0] ovl_rgb = 6'b0;
    logic       show = 1'b0;
    logic [5:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;
    logic [2:0] alpha;
    logic [1:0] fade_state;

    overlay_mixer #(.FADE_FRAMES(FF), .TRANSPARENT(TK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .display_on (display_on),
        .bg_rgb     (bg_rgb),
        .ovl_rgb    (ovl_rgb),
        .show       (show),
        .rgb_out    (rgb_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .alpha      (alpha),
        .fade_state (fade_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: overlay weight with a direction of travel and a frame counter.
    int m_alpha = 0;
    int m_dir = 0;
    int m_frames = 0;
    bit m_fading = 1'b0;

    // Expected outputs in flight: {rgb, hsync, vsync}
    logic [7:0] pipe1 = 8'b00000011;
    logic [7:0] pipe2 = 8'b00000011;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_pix(input logic [5:0] bg, input logic [5:0] ovl,
                                           input logic de, input int a);
        logic [5:0] res;
        int o;
        int b;
        int v;
        res = 6'b0;
        if (!de) return 6'b0;
        if (ovl == TK) return bg;
        for (int ch = 0; ch < 3; ch++) begin
            o = 2 * int'(ovl[5-ch]) + int'(ovl[2-ch]);
            b = 2 * int'(bg[5-ch]) + int'(bg[2-ch]);
            v = (o * a + b * (4 - a)) / 4;
            res[5-ch] = ((v >> 1) & 1) != 0;
            res[2-ch] = (v & 1) != 0;
        end
        return res;
    endfunction

    function automatic int model_state();
        if (m_fading) return (m_dir > 0) ? 1 : 3;
        return (m_alpha == 4) ? 2 : 0;
    endfunction

    task automatic model_tick();
        int tgt;
        int d;
        tgt = show ? 4 : 0;
`ifdef OVERLAY_FADE_EN
        if (!m_fading) begin
            if (m_alpha != tgt) begin
                m_fading = 1'b1;
                m_dir    = (tgt > m_alpha) ? 1 : -1;
                m_alpha  = m_alpha + m_dir;
                m_frames = 0;
            end
        end else begin
            d = (tgt > m_alpha) ? 1 : -1;
            if (d != m_dir) begin
                m_dir    = d;
                m_frames = 0;
            end else begin
                m_frames++;
                if (m_frames == FF) begin
                    m_frames = 0;
                    m_alpha  = m_alpha + m_dir;
                    if (m_alpha == tgt) m_fading = 1'b0;
                end
            end
        end
`else
        d = 0;
        m_alpha = tgt;
        m_dir   = d;
`endif
    endtask

    task automatic cycle(input logic hs, input logic vs, input logic de,
                         input logic [5:0] bg, input logic [5:0] ovl);
        @(negedge clk);
        chk("rgb_out", 8'(rgb_out), 8'(pipe2[7:2]));
        chk("hsync_out", 8'(hsync_out), 8'(pipe2[1]));
        chk("vsync_out", 8'(vsync_out), 8'(pipe2[0]));
        if (vsync_in && !vs) model_tick();
        hsync_in   = hs;
        vsync_in   = vs;
        display_on = de;
        bg_rgb     = bg;
        ovl_rgb    = ovl;
        pipe2 = pipe1;
        pipe1 = {ref_pix(bg, ovl, de, m_alpha), hs, vs};
    endtask

    task automatic frame(input logic sh, input int nvis);
        logic [5:0] bg;
        logic [5:0] ovl;
        logic       de;
        show = sh;
        for (int i = 0; i < 4; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 6'($urandom), 6'($urandom));
        end
        chk("alpha", 8'(alpha), 8'(m_alpha));
        chk("fade_state", 8'(fade_state), 8'(model_state()));
        for (int i = 0; i < nvis; i++) begin
            de = ($urandom_range(0, 7) != 0);
            bg = 6'($urandom);
            ovl = 6'($urandom);
            case (i)
                0: begin bg = 6'b010101; ovl = 6'b111111; de = 1'b1; end
                1: begin bg = 6'b000100; ovl = 6'b100100; de = 1'b1; end
                2: begin ovl = TK; de = 1'b1; end
                3: begin de = 1'b0; end
                default: ;
            endcase
            cycle(($urandom_range(0, 9) != 0), 1'b1, de, bg, ovl);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b1;
        display_on = 1'b0;
        #1;
        chk("rst_rgb", 8'(rgb_out), 8'h00);
        chk("rst_hsync", 8'(hsync_out), 8'h01);
        chk("rst_vsync", 8'(vsync_out), 8'h01);
        chk("rst_alpha", 8'(alpha), 8'h00);
        chk("rst_state", 8'(fade_state), 8'h00);
        m_alpha  = 0;
        m_dir    = 0;
        m_frames = 0;
        m_fading = 1'b0;
        pipe1 = 8'b00000011;
        pipe2 = 8'b00000011;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        chk("por_rgb", 8'(rgb_out), 8'h00);
        chk("por_alpha", 8'(alpha), 8'h00);
        apply_reset();

        // idle, show low: passthrough of background
        frame(1'b0, 30);
        frame(1'b0, 30);

        // fade in for three ticks, alpha reaches 2, then reverse
        for (int i = 0; i < 3; i++) frame(1'b1, 30);
        for (int i = 0; i < 6; i++) frame(1'b0, 30);

        // full fade in to SHOWN, hold, then start fading out
        for (int i = 0; i < 9; i++) frame(1'b1, 30);
        frame(1'b0, 30);

        // reset in the middle of a fade
        apply_reset();
        frame(1'b0, 20);
        frame(1'b0, 20);

        // random show requests
        for (int i = 0; i < 12; i++) frame(1'($urandom_range(0, 1)), 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
